// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer write controller.
package fb_pkg;

  localparam int DW_DEF       = 12;
  localparam int AW_DEF       = 19;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FB_PIXELS    = H_ACTIVE_DEF * V_ACTIVE_DEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_WAIT_SOF = 2'd2,
    ST_CAPTURE  = 2'd3
  } fb_state_t;

  // States in which the pixel stream is accepted.
  function automatic logic is_stream_state(input fb_state_t s);
    return (s == ST_WAIT_SOF) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Raster position counter (x, y and linear address) shared by the clear and capture paths.
// load+inc together restarts at pixel 1, used when the pixel at address 0 is being written now.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int AW       = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  assign last = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst || (load && !inc)) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (load) begin
      x    <= XW'(1);
      y    <= '0;
      addr <= AW'(1);
    end else if (inc) begin
      if (last) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end else if (x == X_LAST) begin
        x    <= '0;
        y    <= y + 1'b1;
        addr <= addr + 1'b1;
      end else begin
        x    <= x + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_wr_ctrl.sv
// Frame-buffer write controller: frame-aligned capture and constant-colour clear on one BRAM port.
// Writes appear one cycle after acceptance; FB_SOF_RESYNC_EN makes a mid-frame SOF restart the frame.
module fb_wr_ctrl
  import fb_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int AW       = AW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cap_en,
  input  logic          i_clr_req,
  input  logic [DW-1:0] i_clr_data,
  input  logic          i_data_valid,
  input  logic          i_data_sof,
  input  logic [DW-1:0] i_data,
  output logic          o_data_ready,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_clr_done,
  output logic          o_sof_err
);

  fb_state_t     state, state_nxt;
  logic          accept;
  logic [DW-1:0] clr_color;
  logic          clr_start;
  logic          clr_last_q;

  logic          ag_load, ag_inc, ag_last;
  logic [AW-1:0] ag_addr;

  logic          wr_en_nxt;
  logic [AW-1:0] wr_addr_nxt;
  logic [DW-1:0] wr_data_nxt;
  logic          frame_done_nxt;
  logic          sof_err_nxt;

  assign accept = i_data_valid & o_data_ready;

  fb_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .AW       (AW)
  ) u_addr_gen (
    .clk  (i_clk),
    .rst  (i_rst),
    .load (ag_load),
    .inc  (ag_inc),
    .addr (ag_addr),
    .last (ag_last)
  );

  always_comb begin
    state_nxt      = state;
    ag_load        = 1'b0;
    ag_inc         = 1'b0;
    clr_start      = 1'b0;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = o_wr_addr;
    wr_data_nxt    = o_wr_data;
    frame_done_nxt = 1'b0;
    sof_err_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_clr_req) begin
          state_nxt = ST_CLEAR;
          ag_load   = 1'b1;
          clr_start = 1'b1;
        end else if (i_cap_en) begin
          state_nxt = ST_WAIT_SOF;
        end
      end

      ST_CLEAR: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = ag_addr;
        wr_data_nxt = clr_color;
        ag_inc      = 1'b1;
        if (ag_last) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_WAIT_SOF: begin
        if (accept && i_data_sof) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = '0;
          wr_data_nxt = i_data;
          ag_load     = 1'b1;
          ag_inc      = 1'b1;
          state_nxt   = ST_CAPTURE;
        end else if (!i_cap_en) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_CAPTURE: begin
        if (accept) begin
          wr_en_nxt   = 1'b1;
          wr_data_nxt = i_data;
          sof_err_nxt = i_data_sof;
`ifdef FB_SOF_RESYNC_EN
          if (i_data_sof) begin
            wr_addr_nxt = '0;
            ag_load     = 1'b1;
            ag_inc      = 1'b1;
          end else begin
            wr_addr_nxt = ag_addr;
            ag_inc      = 1'b1;
            if (ag_last) begin
              frame_done_nxt = 1'b1;
              state_nxt      = i_cap_en ? ST_WAIT_SOF : ST_IDLE;
            end
          end
`else
          // A stray SOF is only reported; the pixel stays in raster order.
          wr_addr_nxt = ag_addr;
          ag_inc      = 1'b1;
          if (ag_last) begin
            frame_done_nxt = 1'b1;
            state_nxt      = i_cap_en ? ST_WAIT_SOF : ST_IDLE;
          end
`endif
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      clr_color    <= '0;
      clr_last_q   <= 1'b0;
      o_data_ready <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_clr_done   <= 1'b0;
      o_sof_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_data_ready <= is_stream_state(state_nxt);
      o_busy       <= (state_nxt != ST_IDLE);
      o_wr_en      <= wr_en_nxt;
      o_wr_addr    <= wr_addr_nxt;
      o_wr_data    <= wr_data_nxt;
      o_frame_done <= frame_done_nxt;
      o_sof_err    <= sof_err_nxt;
      // Done lands one cycle after the final clear write is on the port.
      clr_last_q   <= (state == ST_CLEAR) && ag_last;
      o_clr_done   <= clr_last_q;
      if (clr_start) begin
        clr_color <= i_clr_data;
      end
    end
  end

endmodule

// File: tb/tb_fb_wr_ctrl.sv
// Directed bench for fb_wr_ctrl on a reduced 40x30 raster.
module tb_fb_wr_ctrl;

  localparam int DW = 12;
  localparam int H  = 40;
  localparam int V  = 30;
  localparam int N  = H * V;
  localparam int AW = 11;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_cap_en;
  logic          i_clr_req;
  logic [DW-1:0] i_clr_data;
  logic          i_data_valid;
  logic          i_data_sof;
  logic [DW-1:0] i_data;
  logic          o_data_ready;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_busy;
  logic          o_frame_done;
  logic          o_clr_done;
  logic          o_sof_err;

  always #5 i_clk = ~i_clk;

  fb_wr_ctrl #(.DW(DW), .H_ACTIVE(H), .V_ACTIVE(V), .AW(AW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cap_en     (i_cap_en),
    .i_clr_req    (i_clr_req),
    .i_clr_data   (i_clr_data),
    .i_data_valid (i_data_valid),
    .i_data_sof   (i_data_sof),
    .i_data       (i_data),
    .o_data_ready (o_data_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_clr_done   (o_clr_done),
    .o_sof_err    (o_sof_err)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic [DW-1:0] mem [N];
  int            cyc = 0;
  int            wr_cnt, fd_cnt, fd_no_wen, clr_done_cnt, sof_err_cnt, oob, ready_wen;
  int            first_cyc, last_cyc;
  logic [AW-1:0] fd_addr, sof_err_addr, last_addr, prev_addr;
  logic [DW-1:0] sof_err_data;
  logic          clr_done_ok, prev_wen;

  always @(negedge i_clk) begin
    cyc = cyc + 1;
    if (o_clr_done) begin
      clr_done_cnt = clr_done_cnt + 1;
      clr_done_ok  = prev_wen && (prev_addr == AW'(N - 1)) && !o_wr_en;
    end
    if (o_frame_done) begin
      fd_cnt  = fd_cnt + 1;
      fd_addr = o_wr_addr;
      if (!o_wr_en) fd_no_wen = fd_no_wen + 1;
    end
    if (o_sof_err) begin
      sof_err_cnt  = sof_err_cnt + 1;
      sof_err_addr = o_wr_addr;
      sof_err_data = o_wr_data;
    end
    if (o_wr_en) begin
      if (wr_cnt == 0) first_cyc = cyc;
      last_cyc  = cyc;
      wr_cnt    = wr_cnt + 1;
      last_addr = o_wr_addr;
      if (int'(o_wr_addr) < N) mem[int'(o_wr_addr)] = o_wr_data;
      else oob = oob + 1;
      if (o_data_ready) ready_wen = ready_wen + 1;
    end
    prev_wen  = o_wr_en;
    prev_addr = o_wr_addr;
  end

  task automatic clr_mon();
    wr_cnt = 0; fd_cnt = 0; fd_no_wen = 0; clr_done_cnt = 0; sof_err_cnt = 0;
    oob = 0; ready_wen = 0; first_cyc = 0; last_cyc = 0;
    fd_addr = '0; sof_err_addr = '0; sof_err_data = '0; last_addr = '0;
    clr_done_ok = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 'x;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic v, input logic s, input logic [DW-1:0] d);
    i_data_valid = v;
    i_data_sof   = s;
    i_data       = d;
    step();
  endtask

  task automatic idle(input int n);
    i_data_valid = 1'b0;
    i_data_sof   = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"},      32'(o_data_ready), 32'd0);
    check({pfx, "_wr_en"},      32'(o_wr_en),      32'd0);
    check({pfx, "_wr_addr"},    32'(o_wr_addr),    32'd0);
    check({pfx, "_wr_data"},    32'(o_wr_data),    32'd0);
    check({pfx, "_busy"},       32'(o_busy),       32'd0);
    check({pfx, "_frame_done"}, 32'(o_frame_done), 32'd0);
    check({pfx, "_clr_done"},   32'(o_clr_done),   32'd0);
    check({pfx, "_sof_err"},    32'(o_sof_err),    32'd0);
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i * 37 + 5);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int found;
    int exp_sof_addr;
    int exp_wr;

    i_rst = 1'b1; i_cap_en = 1'b0; i_clr_req = 1'b0; i_clr_data = '0;
    i_data_valid = 1'b0; i_data_sof = 1'b0; i_data = '0;
    clr_mon();
    for (int k = 0; k < 3; k++) step();
    check_reset_outputs("rst");
    i_rst = 1'b0;

    // Full frame with occasional valid gaps.
    i_cap_en = 1'b1;
    for (int k = 0; k < 20 && !o_data_ready; k++) step();
    check("ready_up", 32'(o_data_ready), 32'd1);
    clr_mon();
    send(1'b1, 1'b1, 12'hABC);
    for (int i = 1; i < N; i++) begin
      if (i % 97 == 0) send(1'b0, 1'b0, 12'h000);
      send(1'b1, 1'b0, pat(i));
    end
    idle(2);
    check("f1_wr_cnt", 32'(wr_cnt), 32'(N));
    check("f1_sof_pix", 32'(mem[0]), 32'h0ABC);
    bad = 0;
    for (int i = 1; i < N; i++) if (mem[i] !== pat(i)) bad++;
    check("f1_data_bad", 32'(bad), 32'd0);
    check("f1_oob", 32'(oob), 32'd0);
    check("f1_fd_cnt", 32'(fd_cnt), 32'd1);
    check("f1_fd_addr", 32'(fd_addr), 32'(N - 1));
    check("f1_fd_no_wen", 32'(fd_no_wen), 32'd0);
    check("f1_ready_wait_sof", 32'(o_data_ready), 32'd1);
    check("f1_busy_wait_sof", 32'(o_busy), 32'd1);

    // Pixels before SOF are dropped; then cap_en falls mid-frame.
    clr_mon();
    for (int k = 1; k <= 5; k++) send(1'b1, 1'b0, DW'(k * 12'h111));
    send(1'b1, 1'b1, 12'h777);
    idle(2);
    check("ws_wr_cnt", 32'(wr_cnt), 32'd1);
    check("ws_addr", 32'(last_addr), 32'd0);
    check("ws_data", 32'(mem[0]), 32'h0777);
    for (int i = 1; i < N; i++) begin
      if (i == 101) i_cap_en = 1'b0;
      send(1'b1, 1'b0, pat(i));
    end
    idle(2);
    check("cd_wr_cnt", 32'(wr_cnt), 32'(N));
    check("cd_fd_cnt", 32'(fd_cnt), 32'd1);
    check("cd_fd_addr", 32'(fd_addr), 32'(N - 1));
    check("cd_ready", 32'(o_data_ready), 32'd0);
    check("cd_busy", 32'(o_busy), 32'd0);

    // Clear with simultaneous cap_en; a second request mid-clear is ignored.
    clr_mon();
    i_clr_req = 1'b1; i_clr_data = 12'h0F0; i_cap_en = 1'b1;
    step();
    i_clr_req = 1'b0; i_clr_data = 12'h123;
    for (int k = 0; k < N + 50 && clr_done_cnt == 0; k++) begin
      if (k == 300) begin i_clr_req = 1'b1; i_clr_data = 12'h456; end
      else i_clr_req = 1'b0;
      step();
    end
    i_clr_req = 1'b0;
    idle(2);
    check("clr_wr_cnt", 32'(wr_cnt), 32'(N));
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== 12'h0F0) bad++;
    check("clr_data_bad", 32'(bad), 32'd0);
    check("clr_done_cnt", 32'(clr_done_cnt), 32'd1);
    check("clr_done_after_last", 32'(clr_done_ok), 32'd1);
    check("clr_span", 32'(last_cyc - first_cyc), 32'(N - 1));
    check("clr_ready_low", 32'(ready_wen), 32'd0);
    check("clr_then_wait_sof", 32'(o_data_ready), 32'd1);

    // SOF arriving at pixel index 1000 of a frame.
`ifdef FB_SOF_RESYNC_EN
    exp_sof_addr = 0;
    exp_wr       = N + 1000;
`else
    exp_sof_addr = 1000;
    exp_wr       = N;
`endif
    clr_mon();
    send(1'b1, 1'b1, pat(0));
    for (int i = 1; i < 1000; i++) send(1'b1, 1'b0, pat(i));
    send(1'b1, 1'b1, 12'hDEF);
    i_cap_en = 1'b0;
    for (int k = 0; k < N + 50 && fd_cnt == 0; k++) send(1'b1, 1'b0, pat(k + 2000));
    idle(2);
    check("se_cnt", 32'(sof_err_cnt), 32'd1);
    check("se_addr", 32'(sof_err_addr), 32'(exp_sof_addr));
    check("se_data", 32'(sof_err_data), 32'h0DEF);
    check("se_mem", 32'(mem[exp_sof_addr]), 32'h0DEF);
    check("se_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
    check("se_fd_cnt", 32'(fd_cnt), 32'd1);
    check("se_ready", 32'(o_data_ready), 32'd0);

    // Reset while the clear is at address 500.
    i_clr_req = 1'b1; i_clr_data = 12'h5A5;
    step();
    i_clr_req = 1'b0;
    found = 0;
    for (int k = 0; k < N && found == 0; k++) begin
      step();
      if (o_wr_en && o_wr_addr == AW'(500)) found = 1;
    end
    check("rc_reached_500", 32'(found), 32'd1);
    i_rst = 1'b1;
    step();
    check_reset_outputs("rc");
    i_rst = 1'b0;
    clr_mon();
    idle(N + 20);
    check("rc_no_clr_done", 32'(clr_done_cnt), 32'd0);
    check("rc_no_writes", 32'(wr_cnt), 32'd0);
    check("rc_idle", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
